register_cmd_initiator: RTL and testbench
=========================================

# register_cmd_initiator

Initiator side of the inband register bus. Takes register read/write commands as a 32-bit word stream from the inband command parser, drives the `enable`/`addr`/`datain` lines of the register I/O responder, and captures its `dataout`. It returns a two-word reply for every read and sits between the control-channel packet decoder and the register file.

## Interface
Parameters:
- `MAX_ADDR`, default 52: highest writable register address. Writes above it are dropped.
- `CNT_W`, default 16: width of the read and write transaction counters.

Ports:
- `clk`  in  1  system clock. Sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_data`  in  32  command word.
- `cmd_valid`  in  1  command word valid.
- `cmd_ready`  out  1  command word accepted when high together with `cmd_valid`.
- `reg_enable`  out  2  to responder `enable`. `[1]` = bus active, `[0]` = 1 for read, 0 for write.
- `reg_addr`  out  7  to responder `addr`.
- `reg_wdata`  out  32  to responder `datain`.
- `reg_rdata`  in  32  from responder `dataout`. Combinational on the responder side.
- `rsp_data`  out  32  reply word.
- `rsp_valid`  out  1  reply word valid.
- `rsp_ready`  in  1  reply sink ready.
- `busy`  out  1  high in any state other than IDLE.
- `rd_count`  out  CNT_W  completed reads. Wraps.
- `wr_count`  out  CNT_W  strobed writes. Wraps.
- `err_count`  out  8  dropped writes. Saturates at 255.

## Operation
- Header word fields:
  - `[31]` rw: 1 = read.
  - `[30:24]` addr.
  - `[23:16]` rid (request ID).
  - `[15:0]` ignored.
- A write header is followed by exactly one data word. A read is header only.
- States and transitions:
  - **IDLE**: `cmd_ready`=1. On a header handshake, latch addr, rid and rw. Go to RD_ACC if rw=1, else to WR_DATA.
  - **WR_DATA**: `cmd_ready`=1. On handshake, latch the data word.
    - If addr ≤ MAX_ADDR: go to WR_STB.
    - Otherwise: increment `err_count` and go to IDLE.
  - **WR_STB**: `cmd_ready`=0. `reg_enable`=2'b10 and `reg_addr`/`reg_wdata` are driven for exactly one cycle. Increment `wr_count`, then go to IDLE.
  - **RD_ACC**: `cmd_ready`=0. `reg_enable`=2'b11 and `reg_addr`=addr for exactly one cycle. Capture `reg_rdata` into the read-data register at the closing edge, then go to RSP_HDR.
  - **RSP_HDR**: `rsp_valid`=1, `rsp_data`={rid, 1'b0, addr, 16'h0000}. On handshake go to RSP_DAT.
  - **RSP_DAT**: `rsp_valid`=1, `rsp_data`=captured read data. On handshake, increment `rd_count` and go to IDLE.
- Outside WR_STB and RD_ACC, `reg_enable`=2'b00.
- Reads have no address check. The responder's value (32'hFFFFFFFF for unmapped addresses) is returned unchanged.
- Write-only registers 51 and 52 are reached through writes. Reading them returns their latched setting.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset and 1 in the first cycle after it.
  - `reg_enable`=2'b00, `reg_addr`=0, `reg_wdata`=0.
  - `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - All counters = 0.
  - State = IDLE.
- All outputs are registered. `reg_*` change only on `clk` edges, so the responder's combinational strobe is glitch-free for a full cycle.
- Read latency: header accepted at edge N, then `reg_enable`=11 during cycle N+1, then `rsp_valid` at N+2. Minimum 4 cycles header-to-IDLE with `rsp_ready` held high.
- Write latency: data accepted at edge M, then strobe cycle M+1, then IDLE at M+2. Minimum 3 cycles per write.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, `rsp_data` holds stable. The module never withdraws `rsp_valid`.
- Idle gaps on `cmd_valid` between header and data are allowed, with no timeout.
- Reset mid-operation returns to IDLE and abandons the in-flight command:
  - No strobe is issued.
  - A pending reply is discarded.
  - The counters clear.
- Simultaneous events:
  - A counter increment coinciding with reset: reset wins.
  - `err_count` at 255 stays at 255.

## Structure
- Shared package `inband_reg_pkg` holds:
  - the state enum;
  - header field bit positions (RW_BIT, ADDR_MSB/LSB, RID_MSB/LSB);
  - the `reg_enable` codes (EN_IDLE=2'b00, EN_WR=2'b10, EN_RD=2'b11);
  - the default MAX_ADDR.
- Single flat module with no sub-modules. The reply path is the two-state RSP_HDR/RSP_DAT sequence, not a FIFO.

## Test plan
- Write: header 32'h33_05_0000 (addr 51, rid 5), data 32'h0000_1234. Expect exactly one cycle of `reg_enable`=10, `reg_addr`=51, `reg_wdata`=32'h1234. Then `wr_count`=1 and no reply.
- Read-back: header 32'hB3_06_0000 after the previous write, with the responder model returning setting_reg 51. Expect replies 32'h0633_0000 then 32'h0000_1234, and `rd_count`=1.
- Unmapped read: addr 60. Expect data reply 32'hFFFFFFFF.
- Dropped write: addr 100 (header 32'h64_01_0000). Expect no `reg_enable`=10 cycle and `err_count`=1.
- Saturation: 300 dropped writes. Expect `err_count`=255.
- Backpressure: `rsp_ready`=0 for 10 cycles on a read.
  - `rsp_data` stays at the header word.
  - `cmd_ready`=0 throughout.
  - Release gives both words in order.
- Reset mid-operation: assert reset in WR_DATA and separately in RSP_HDR.
  - Next cycle: `reg_enable`=00, `rsp_valid`=0, counters 0.
  - A following read completes normally.

Source files
------------

// File: rtl/inband_reg_pkg.sv
// Shared definitions for the inband register bus: FSM states, command header
// layout, responder strobe codes and the default writable address limit.
package inband_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_STB,
        ST_RD_ACC,
        ST_RSP_HDR,
        ST_RSP_DAT
    } state_e;

    localparam int RW_BIT   = 31;
    localparam int ADDR_MSB = 30;
    localparam int ADDR_LSB = 24;
    localparam int RID_MSB  = 23;
    localparam int RID_LSB  = 16;

    localparam logic [1:0] EN_IDLE = 2'b00;
    localparam logic [1:0] EN_WR   = 2'b10;
    localparam logic [1:0] EN_RD   = 2'b11;

    localparam int DEFAULT_MAX_ADDR = 52;

    // First reply word of a read: echoes the request ID and register address.
    function automatic logic [31:0] rsp_header(input logic [7:0] rid, input logic [6:0] addr);
        return {rid, 1'b0, addr, 16'h0000};
    endfunction

endpackage

// File: rtl/register_cmd_initiator.sv
// Initiator side of the inband register bus: turns header/data command words into
// one-cycle responder strobes and returns a two-word reply for every read.
module register_cmd_initiator
    import inband_reg_pkg::*;
#(
    parameter int MAX_ADDR = DEFAULT_MAX_ADDR,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [1:0]       reg_enable,
    output logic [6:0]       reg_addr,
    output logic [31:0]      reg_wdata,
    input  logic [31:0]      reg_rdata,
    output logic [31:0]      rsp_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic [7:0]       err_count
);

    state_e           state_q, state_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       rid_q, rid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [1:0]       reg_enable_q, reg_enable_d;
    logic [6:0]       reg_addr_q, reg_addr_d;
    logic [31:0]      reg_wdata_q, reg_wdata_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [7:0]       err_count_q, err_count_d;

    logic cmd_fire;
    logic addr_ok;
    logic cmd_unused;

    assign cmd_fire   = cmd_valid && cmd_ready_q;
    assign addr_ok    = ({25'd0, addr_q} <= $unsigned(MAX_ADDR));
    assign cmd_unused = ^cmd_data[RID_LSB-1:0];

    always_comb begin
        // NOTE: every _d takes a default first so no path through the case statements infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        rid_d        = rid_q;
        rdata_d      = rdata_q;
        reg_wdata_d  = reg_wdata_q;
        reg_addr_d   = reg_addr_q;
        rsp_data_d   = rsp_data_q;
        rd_count_d   = rd_count_q;
        wr_count_d   = wr_count_q;
        err_count_d  = err_count_q;
        cmd_ready_d  = 1'b0;
        reg_enable_d = EN_IDLE;
        rsp_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    addr_d  = cmd_data[ADDR_MSB:ADDR_LSB];
                    rid_d   = cmd_data[RID_MSB:RID_LSB];
                    state_d = cmd_data[RW_BIT] ? ST_RD_ACC : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (cmd_fire) begin
                    if (addr_ok) begin
                        reg_wdata_d = cmd_data;
                        state_d     = ST_WR_STB;
                    end else begin
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WR_STB: begin
                wr_count_d = wr_count_q + CNT_W'(1);
                state_d    = ST_IDLE;
            end
            ST_RD_ACC: begin
                rdata_d = reg_rdata;
                state_d = ST_RSP_HDR;
            end
            ST_RSP_HDR: begin
                if (rsp_ready) begin
                    state_d = ST_RSP_DAT;
                end
            end
            ST_RSP_DAT: begin
                if (rsp_ready) begin
                    rd_count_d = rd_count_q + CNT_W'(1);
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops already aligned to it.
        case (state_d)
            ST_IDLE, ST_WR_DATA: cmd_ready_d = 1'b1;
            ST_WR_STB: begin
                reg_enable_d = EN_WR;
                reg_addr_d   = addr_d;
            end
            ST_RD_ACC: begin
                reg_enable_d = EN_RD;
                reg_addr_d   = addr_d;
            end
            ST_RSP_HDR: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rsp_header(rid_d, addr_d);
            end
            ST_RSP_DAT: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rdata_d;
            end
            default: cmd_ready_d = 1'b0;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rid_q        <= '0;
            rdata_q      <= '0;
            cmd_ready_q  <= 1'b0;
            reg_enable_q <= EN_IDLE;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
            err_count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            addr_q       <= addr_d;
            rid_q        <= rid_d;
            rdata_q      <= rdata_d;
            cmd_ready_q  <= cmd_ready_d;
            reg_enable_q <= reg_enable_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign reg_enable = reg_enable_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign busy       = busy_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_register_cmd_initiator.sv
// Bench for register_cmd_initiator: a register-file responder, a transaction-level
// model of expected strobes/replies/counters, and a per-cycle compare process.
module tb_register_cmd_initiator;

    localparam int MAX_ADDR = 52;
    localparam int CNT_W    = 16;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
    } stb_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      cmd_data = '0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       reg_enable;
    logic [6:0]       reg_addr;
    logic [31:0]      reg_wdata;
    logic [31:0]      reg_rdata;
    logic [31:0]      rsp_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             busy;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;
    logic [7:0]       err_count;

    register_cmd_initiator #(.MAX_ADDR(MAX_ADDR), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .reg_enable(reg_enable), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .busy(busy), .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    endtask

    // ---------------- responder: register file, unmapped reads return all ones
    logic [31:0] resp_mem [0:127];

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign reg_rdata = (reg_addr > 7'(MAX_ADDR)) ? 32'hFFFF_FFFF : resp_mem[reg_addr];

    initial begin
        for (int i = 0; i < 128; i++) resp_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (reg_enable == 2'b10 && reg_addr <= 7'(MAX_ADDR)) resp_mem[reg_addr] = reg_wdata;
        end
    end

    // ---------------- reply sink: 0 = always ready, 1 = random, 2 = stalled
    int rdy_mode = 0;
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // ---------------- transaction-level model
    logic [31:0]      model_mem [0:127];
    logic [CNT_W-1:0] model_rd  = '0;
    logic [CNT_W-1:0] model_wr  = '0;
    int               model_err = 0;
    stb_t             exp_stb[$];
    logic [6:0]       exp_rd[$];
    logic [31:0]      exp_rsp[$];
    logic [31:0]      rx_log[$];
    int               stb_cycles = 0;

    initial for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);

    // ---------------- per-cycle compare
    initial begin : compare
        logic        prev_stb;
        logic        prev_hold;
        logic [31:0] prev_data;
        stb_t        s;
        logic [31:0] w;
        logic [6:0]  ra;
        prev_stb  = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stb  = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                    check("rsp_hold_data", rsp_data, prev_data);
                end
                check("enable_code_legal", 32'(reg_enable == 2'b01), 32'd0);
                if (!busy) begin
                    check("idle_enable", 32'(reg_enable), 32'd0);
                    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                end
                if (reg_enable == 2'b10) begin
                    stb_cycles++;
                    check("strobe_single_cycle", 32'(prev_stb), 32'd0);
                    check("strobe_expected", 32'(exp_stb.size() != 0), 32'd1);
                    if (exp_stb.size() != 0) begin
                        s = exp_stb.pop_front();
                        check("strobe_addr", 32'(reg_addr), 32'(s.addr));
                        check("strobe_wdata", reg_wdata, s.data);
                    end
                end
                if (reg_enable == 2'b11) begin
                    check("read_expected", 32'(exp_rd.size() != 0), 32'd1);
                    if (exp_rd.size() != 0) begin
                        ra = exp_rd.pop_front();
                        check("read_addr", 32'(reg_addr), 32'(ra));
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    rx_log.push_back(rsp_data);
                    check("reply_expected", 32'(exp_rsp.size() != 0), 32'd1);
                    if (exp_rsp.size() != 0) begin
                        w = exp_rsp.pop_front();
                        check("reply_word", rsp_data, w);
                    end
                end
                prev_stb  = (reg_enable == 2'b10);
                prev_hold = rsp_valid && !rsp_ready;
                prev_data = rsp_data;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accepted", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cmd_write(input logic [31:0] hdr, input logic [31:0] data, input int gap);
        logic [6:0] a;
        a = hdr[30:24];
        send_word(hdr);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        if (int'(a) <= MAX_ADDR) begin
            exp_stb.push_back('{addr: a, data: data});
            model_mem[a] = data;
            model_wr++;
        end else if (model_err < 255) begin
            model_err++;
        end
        send_word(data);
    endtask

    task automatic cmd_read(input logic [31:0] hdr);
        logic [6:0] a;
        logic [7:0] rid;
        a   = hdr[30:24];
        rid = hdr[23:16];
        exp_rd.push_back(a);
        exp_rsp.push_back({rid, 1'b0, a, 16'h0000});
        exp_rsp.push_back((int'(a) > MAX_ADDR) ? 32'hFFFF_FFFF : model_mem[a]);
        model_rd++;
        send_word(hdr);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        check("rd_count", 32'(rd_count), 32'(model_rd));
        check("wr_count", 32'(wr_count), 32'(model_wr));
        check("err_count", 32'(err_count), 32'(model_err));
        check("strobes_drained", 32'(exp_stb.size()), 32'd0);
        check("replies_drained", 32'(exp_rsp.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_reg_enable", 32'(reg_enable), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_wdata", reg_wdata, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_stb.delete();
        exp_rd.delete();
        exp_rsp.delete();
        model_rd  = '0;
        model_wr  = '0;
        model_err = 0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence
    initial begin
        int s0;
        int r0;
        int n;
        logic [6:0]  a;
        logic [31:0] hdr;

        do_reset();

        // Write to write-only register 51: one strobe cycle, no reply.
        s0 = stb_cycles;
        r0 = rx_log.size();
        cmd_write(32'h3305_0000, 32'h0000_1234, 0);
        @(negedge clk);
        check("wr_strobe_enable", 32'(reg_enable), 32'h2);
        check("wr_strobe_addr", 32'(reg_addr), 32'd51);
        check("wr_strobe_data", reg_wdata, 32'h0000_1234);
        @(negedge clk);
        check("wr_idle_after_strobe", 32'(busy), 32'd0);
        wait_idle();
        check("wr_strobe_count", 32'(stb_cycles - s0), 32'd1);
        check("wr_count_literal", 32'(wr_count), 32'd1);
        check("wr_no_reply", 32'(rx_log.size() - r0), 32'd0);

        // Read back register 51.
        r0 = rx_log.size();
        cmd_read(32'hB306_0000);
        @(negedge clk);
        check("rd_acc_enable", 32'(reg_enable), 32'h3);
        check("rd_acc_addr", 32'(reg_addr), 32'd51);
        @(negedge clk);
        check("rd_rsp_latency", 32'(rsp_valid), 32'd1);
        wait_idle();
        check("rd_reply_count", 32'(rx_log.size() - r0), 32'd2);
        if (rx_log.size() - r0 == 2) begin
            check("rd_hdr_literal", rx_log[r0], 32'h0633_0000);
            check("rd_data_literal", rx_log[r0+1], 32'h0000_1234);
        end
        check("rd_count_literal", 32'(rd_count), 32'd1);

        // Unmapped read at address 60.
        r0 = rx_log.size();
        cmd_read(32'hBC07_0000);
        wait_idle();
        if (rx_log.size() - r0 == 2) begin
            check("unmapped_hdr_literal", rx_log[r0], 32'h073C_0000);
            check("unmapped_data_literal", rx_log[r0+1], 32'hFFFF_FFFF);
        end else check("unmapped_reply_count", 32'(rx_log.size() - r0), 32'd2);

        // Dropped write at address 100.
        s0 = stb_cycles;
        cmd_write(32'h6401_0000, 32'hDEAD_BEEF, 0);
        wait_idle();
        check("drop_no_strobe", 32'(stb_cycles - s0), 32'd0);
        check("drop_err_literal", 32'(err_count), 32'd1);

        // 299 more dropped writes saturate err_count.
        for (int i = 0; i < 299; i++) begin
            a = 7'($urandom_range(MAX_ADDR + 1, 127));
            cmd_write({1'b0, a, 8'(i), 16'(i)}, $urandom, $urandom_range(0, 1));
            wait_idle();
        end
        check("err_saturated_literal", 32'(err_count), 32'd255);
        check("sat_no_strobe", 32'(stb_cycles - s0), 32'd0);

        // Backpressure on a read of register 51.
        r0 = rx_log.size();
        rdy_mode = 2;
        cmd_read(32'hB309_0000);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_hdr_stable", rsp_data, 32'h0933_0000);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rdy_mode = 0;
        wait_idle();
        if (rx_log.size() - r0 == 2) begin
            check("bp_hdr_order", rx_log[r0], 32'h0933_0000);
            check("bp_data_order", rx_log[r0+1], 32'h0000_1234);
        end else check("bp_reply_count", 32'(rx_log.size() - r0), 32'd2);

        // Reset while waiting for write data at address 10.
        s0 = stb_cycles;
        send_word(32'h0A11_0000);
        @(negedge clk);
        check("wr_data_wait_busy", 32'(busy), 32'd1);
        check("wr_data_wait_ready", 32'(cmd_ready), 32'd1);
        do_reset();
        cmd_read(32'h8A12_0000);
        wait_idle();
        check("abandoned_write_no_strobe", 32'(stb_cycles - s0), 32'd0);

        // Reset while the reply header is pending.
        rdy_mode = 2;
        cmd_read(32'hAD20_0000);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pending_hdr_literal", rsp_data, 32'h202D_0000);
        do_reset();
        rdy_mode = 0;
        cmd_read(32'hAD21_0000);
        wait_idle();
        check("post_reset_rd_count", 32'(rd_count), 32'd1);

        // Randomized traffic with random sink stalls and header/data gaps.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(MAX_ADDR + 1, 127));
            else a = 7'($urandom_range(0, MAX_ADDR));
            hdr = {1'($urandom_range(0, 1)), a, 8'($urandom), 16'($urandom)};
            if (hdr[31]) cmd_read(hdr);
            else cmd_write(hdr, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        rdy_mode = 0;
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
